// File: rtl/flog_pkg.sv
// bfloat16 field widths shared by the flog unit and its arbiter.
package flog_pkg;
    localparam int EXP_WIDTH   = 8;
    localparam int FRACT_WIDTH = 7;
endpackage

// File: rtl/flog_arbiter_if.sv
// Requester, flog-unit and response handshakes of flog_arbiter in one bundle.
interface flog_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int EW   = flog_pkg::EXP_WIDTH;
    localparam int FW   = flog_pkg::FRACT_WIDTH;
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid_i;
    logic [16*N_REQ-1:0] req_data_i;
    logic [N_REQ-1:0]    req_ready_o;

    logic                flog_valid_o;
    logic                flog_sign_o;
    logic [EW-1:0]       flog_exp_o;
    logic [FW-1:0]       flog_fract_o;
    logic                flog_valid_i;
    logic                flog_sign_i;
    logic [EW-1:0]       flog_exp_i;
    logic [FW-1:0]       flog_fract_i;

    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [ID_W-1:0]     rsp_id_o;
    logic [15:0]         rsp_data_o;
    logic                rsp_err_o;
    logic                busy_o;
    logic                err_o;

    modport master (
        output req_valid_i, req_data_i, rsp_ready_i,
               flog_valid_i, flog_sign_i, flog_exp_i, flog_fract_i,
        input  req_ready_o, flog_valid_o, flog_sign_o, flog_exp_o, flog_fract_o,
               rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o, err_o
    );

    modport slave (
        input  req_valid_i, req_data_i, rsp_ready_i,
               flog_valid_i, flog_sign_i, flog_exp_i, flog_fract_i,
        output req_ready_o, flog_valid_o, flog_sign_o, flog_exp_o, flog_fract_o,
               rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o, err_o
    );
endinterface

// File: rtl/flog_arbiter.sv
// Round-robin arbiter sharing one bfloat16 log2 unit between N_REQ requesters,
// with a watchdog that turns a hung operation into a QNaN error response.
module flog_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input logic           clk,
    input logic           rst,
    flog_arbiter_if.slave bus
);
    localparam int EW    = flog_pkg::EXP_WIDTH;
    localparam int FW    = flog_pkg::FRACT_WIDTH;
    localparam int DW    = 1 + EW + FW;
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DW-1:0]    QNAN     = DW'(16'h7FC0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;

    logic [ID_W-1:0]  rr_ptr, grant_id, grant_idx, cand;
    logic             grant_hit;
    logic [N_REQ-1:0] grant_oh;
    logic [DW-1:0]    op_word [N_REQ];
    logic [DW-1:0]    res_word;
    logic [CNT_W-1:0] wd_cnt;
    logic             accept, res_take, wd_fire, rsp_done;
    logic             issue_q, rsp_valid_q, rsp_err_q, err_q;
    logic [DW-1:0]    op_q, rsp_data_q;

    for (genvar g = 0; g < N_REQ; g++) begin : g_op
        assign op_word[g] = bus.req_data_i[DW*g +: DW];
    end

    assign res_word = {bus.flog_sign_i, bus.flog_exp_i, bus.flog_fract_i};

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % N_REQ);
            if (!grant_hit && bus.req_valid_i[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (state == IDLE && grant_hit) grant_oh[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        res_take = 1'b0;
        wd_fire  = 1'b0;
        rsp_done = 1'b0;
        case (state)
            IDLE: begin
                if (grant_hit) begin
                    accept   = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (bus.flog_valid_i) begin
                    res_take = 1'b1;
                    state_nx = RESP;
                end else if (wd_cnt == CNT_LAST) begin
                    wd_fire  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_done = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            op_q        <= '0;
            issue_q     <= 1'b0;
            wd_cnt      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            issue_q <= accept;
            if (accept) begin
                op_q     <= op_word[grant_idx];
                grant_id <= grant_idx;
            end
            if (state == ISSUE)     wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (res_take) begin
                rsp_data_q <= res_word;
                rsp_err_q  <= 1'b0;
            end
            if (wd_fire) begin
                rsp_data_q <= QNAN;
                rsp_err_q  <= 1'b1;
            end
            if (res_take || wd_fire) rsp_valid_q <= 1'b1;
            else if (rsp_done)       rsp_valid_q <= 1'b0;
            if (rsp_done) rr_ptr <= (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
            // Results arriving outside WAIT (e.g. after a timeout) are dropped but flagged.
            if (wd_fire || (bus.flog_valid_i && state != WAIT)) err_q <= 1'b1;
        end
    end

    assign bus.req_ready_o = grant_oh;
    assign bus.flog_valid_o = issue_q;
    assign {bus.flog_sign_o, bus.flog_exp_o, bus.flog_fract_o} = op_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_id_o    = grant_id;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.busy_o      = (state != IDLE);
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_flog_arbiter.sv
// Self-checking bench for flog_arbiter: stubbed log2 unit, queued requesters,
// round-robin reference model.
module tb_flog_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flog_arbiter_if #(.N_REQ(N)) bus ();
    flog_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int issue_cnt = 0;
    always @(posedge clk) if (bus.flog_valid_o === 1'b1) issue_cnt <= issue_cnt + 1;

    // Known log2 points; other operands map through an arbitrary bijection,
    // which is enough since the arbiter only forwards data.
    function automatic logic [15:0] unit_model(input logic [15:0] x);
        case (x)
            16'h3F80: return 16'h0000;
            16'h4000: return 16'h3F80;
            16'h0000: return 16'hFF80;
            16'hBF80: return 16'h7FC0;
            16'h7F80: return 16'h7F80;
            default:  return x ^ 16'hA5C3;
        endcase
    endfunction

    int          lat      = 1;
    bit          mute     = 1'b0;
    bit          rand_lat = 1'b0;
    int          inj_cnt  = 0;
    int          inj_seen = 0;
    int          pend     = 0;
    int          cd       = 0;
    logic [15:0] held     = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.flog_valid_i <= 1'b0;
            {bus.flog_sign_i, bus.flog_exp_i, bus.flog_fract_i} <= '0;
            pend <= 0;
            cd   <= 0;
        end else begin
            bus.flog_valid_i <= 1'b0;
            if (bus.flog_valid_o && !mute) begin
                if (lat <= 1) begin
                    bus.flog_valid_i <= 1'b1;
                    {bus.flog_sign_i, bus.flog_exp_i, bus.flog_fract_i} <=
                        unit_model({bus.flog_sign_o, bus.flog_exp_o, bus.flog_fract_o});
                end else begin
                    pend <= 1;
                    cd   <= lat - 2;
                    held <= {bus.flog_sign_o, bus.flog_exp_o, bus.flog_fract_o};
                end
            end else if (pend != 0) begin
                if (cd == 0) begin
                    bus.flog_valid_i <= 1'b1;
                    {bus.flog_sign_i, bus.flog_exp_i, bus.flog_fract_i} <= unit_model(held);
                    pend <= 0;
                end else cd <= cd - 1;
            end
            if (inj_cnt != inj_seen) begin
                inj_seen         <= inj_cnt;
                bus.flog_valid_i <= 1'b1;
                {bus.flog_sign_i, bus.flog_exp_i, bus.flog_fract_i} <= 16'h1234;
            end
        end
    end

    logic [15:0] op_mem [N][8];
    int          head [N];
    int          tail [N];
    int          model_ptr = 0;
    int          exp_id [$];
    logic [15:0] exp_data [$];
    int          obs_id [$];
    logic [15:0] obs_data [$];
    logic        obs_err [$];
    int          acc_cyc [$];
    int          rv_cyc [$];
    int          grant_log [$];
    bit          timed_out;

    task automatic clear_bench();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        exp_id.delete(); exp_data.delete();
        obs_id.delete(); obs_data.delete(); obs_err.delete();
        acc_cyc.delete(); rv_cyc.delete(); grant_log.delete();
    endtask

    task automatic push_op(input int r, input logic [15:0] v);
        op_mem[r][tail[r]] = v;
        tail[r]++;
    endtask

    // Reference: repeatedly serve the first non-empty requester from the pointer.
    task automatic build_expect();
        int h [N];
        int left = 0;
        for (int i = 0; i < N; i++) begin
            h[i] = head[i];
            left += tail[i] - head[i];
        end
        while (left > 0) begin
            for (int k = 0; k < N; k++) begin
                int r;
                r = (model_ptr + k) % N;
                if (h[r] < tail[r]) begin
                    exp_id.push_back(r);
                    exp_data.push_back(unit_model(op_mem[r][h[r]]));
                    h[r]++;
                    left--;
                    model_ptr = (r + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic engine(input int exp_n, input int budget, input bit rand_ready);
        int got = 0;
        int c = 0;
        bit rv_seen = 1'b0;
        while (got < exp_n && c < budget) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                bus.req_valid_i[i] = (head[i] < tail[i]);
                if (head[i] < tail[i]) bus.req_data_i[16*i +: 16] = op_mem[i][head[i]];
                else                   bus.req_data_i[16*i +: 16] = 16'h0000;
            end
            bus.rsp_ready_i = rand_ready ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (rand_lat) lat = $urandom_range(1, 6);
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid_i[i] && bus.req_ready_o[i]) begin
                    grant_log.push_back(i);
                    acc_cyc.push_back(cyc);
                    head[i]++;
                end
            end
            if (bus.rsp_valid_o && !rv_seen) begin
                rv_seen = 1'b1;
                rv_cyc.push_back(cyc);
            end
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                obs_id.push_back(int'(bus.rsp_id_o));
                obs_data.push_back(bus.rsp_data_o);
                obs_err.push_back(bus.rsp_err_o);
                got++;
                rv_seen = 1'b0;
            end
            c++;
        end
        timed_out = (got < exp_n);
        @(posedge clk); #1;
        bus.req_valid_i = '0;
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid_i = '0;
        bus.rsp_ready_i = 1'b0;
        mute = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_ptr = 0;
        clear_bench();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        total++; if (bus.req_ready_o !== '0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready_o); end
        total++; if (bus.flog_valid_o !== 1'b0) begin bad++; $display("FAIL reset_flog_valid got=%b want=0", bus.flog_valid_o); end
        total++; if ({bus.flog_sign_o, bus.flog_exp_o, bus.flog_fract_o} !== 16'h0) begin bad++; $display("FAIL reset_operand got=%h want=0000", {bus.flog_sign_o, bus.flog_exp_o, bus.flog_fract_o}); end
        total++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_id_o} !== '0) begin bad++; $display("FAIL reset_rsp_ctl got v=%b e=%b id=%0d want 0", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_id_o); end
        total++; if (bus.rsp_data_o !== 16'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0000", bus.rsp_data_o); end
        total++; if ({bus.busy_o, bus.err_o} !== 2'b00) begin bad++; $display("FAIL reset_busy_err got=%b%b want=00", bus.busy_o, bus.err_o); end
        @(negedge clk);
        rst = 1'b1;
        model_ptr = 0;
        clear_bench();
    endtask

    task automatic test_single();
        int ic;
        lat = 1;
        push_op(0, 16'h3F80);
        build_expect();
        ic = issue_cnt;
        engine(1, 50, 1'b0);
        total++; if (timed_out) begin bad++; $display("FAIL single_done got=timeout want=response"); end
        total++; if (obs_id.size() != 1 || obs_id[0] !== 0 || obs_data[0] !== 16'h0000 || obs_err[0] !== 1'b0)
            begin bad++; $display("FAIL single_rsp got n=%0d want id=0 data=0000 err=0", obs_id.size()); end
        total++; if (issue_cnt - ic != 1) begin bad++; $display("FAIL single_issue got=%0d want=1", issue_cnt - ic); end
        total++; if (rv_cyc.size() != 1 || acc_cyc.size() != 1 || rv_cyc[0] - acc_cyc[0] != lat + 2)
            begin bad++; $display("FAIL single_latency got acc=%0d rv=%0d want diff=%0d", acc_cyc.size(), rv_cyc.size(), lat + 2); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL single_err got=%b want=0", bus.err_o); end
        clear_bench();
    endtask

    task automatic test_req2_pair();
        lat = 3;
        push_op(2, 16'h4000);
        push_op(2, 16'h0000);
        build_expect();
        engine(2, 80, 1'b0);
        total++; if (timed_out || obs_id.size() != 2) begin bad++; $display("FAIL pair_count got=%0d want=2", obs_id.size()); end
        for (int k = 0; k < obs_id.size() && k < exp_id.size(); k++) begin
            total++;
            if (obs_id[k] !== exp_id[k] || obs_data[k] !== exp_data[k] || obs_err[k] !== 1'b0) begin
                bad++;
                $display("FAIL pair_rsp[%0d] got id=%0d data=%h err=%b want id=%0d data=%h err=0",
                         k, obs_id[k], obs_data[k], obs_err[k], exp_id[k], exp_data[k]);
            end
        end
        clear_bench();
    endtask

    task automatic test_all_four();
        do_reset();
        lat = 1;
        push_op(0, 16'h3F80);
        push_op(1, 16'h4000);
        push_op(2, 16'hBF80);
        push_op(3, 16'h7F80);
        build_expect();
        engine(4, 100, 1'b0);
        total++; if (timed_out || obs_id.size() != 4) begin bad++; $display("FAIL four_count got=%0d want=4", obs_id.size()); end
        for (int k = 0; k < obs_id.size() && k < exp_id.size(); k++) begin
            total++;
            if (grant_log[k] !== k || obs_id[k] !== exp_id[k] || obs_data[k] !== exp_data[k] || obs_err[k] !== 1'b0) begin
                bad++;
                $display("FAIL four_rsp[%0d] got grant=%0d id=%0d data=%h err=%b want grant=%0d data=%h err=0",
                         k, grant_log[k], obs_id[k], obs_data[k], obs_err[k], k, exp_data[k]);
            end
        end
        for (int k = 0; k + 1 < acc_cyc.size() && k < rv_cyc.size(); k++) begin
            total++;
            if (acc_cyc[k+1] != rv_cyc[k] + 1) begin
                bad++;
                $display("FAIL four_b2b[%0d] got accept=%0d want=%0d", k, acc_cyc[k+1], rv_cyc[k] + 1);
            end
        end
        clear_bench();
    endtask

    task automatic test_stall();
        bit ok = 1'b0;
        int ic;
        lat = 2;
        bus.rsp_ready_i = 1'b0;
        @(posedge clk); #1;
        bus.req_valid_i = 4'b0010;
        bus.req_data_i[31:16] = 16'h4000;
        for (int c = 0; c < 20 && !ok; c++) begin @(negedge clk); ok = bus.req_ready_o[1]; end
        total++; if (!ok) begin bad++; $display("FAIL stall_grant got=none want=req1"); end
        @(posedge clk); #1;
        bus.req_valid_i = 4'b1000;
        bus.req_data_i[63:48] = 16'h7F80;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin @(negedge clk); ok = bus.rsp_valid_o; end
        total++; if (!ok) begin bad++; $display("FAIL stall_rsp got=none want=rsp_valid"); end
        ic = issue_cnt;
        for (int c = 0; c < 10; c++) begin
            total++;
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== unit_model(16'h4000) || bus.rsp_id_o !== 2'd1 ||
                bus.rsp_err_o !== 1'b0 || bus.req_ready_o !== 4'b0000) begin
                bad++;
                $display("FAIL stall_hold[%0d] got v=%b data=%h id=%0d err=%b ready=%b want v=1 data=%h id=1 err=0 ready=0000",
                         c, bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o, bus.req_ready_o, unit_model(16'h4000));
            end
            @(negedge clk);
        end
        total++; if (issue_cnt != ic) begin bad++; $display("FAIL stall_issue got=%0d want=%0d", issue_cnt, ic); end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.req_valid_i = '0;
        bus.rsp_ready_i = 1'b0;
        model_ptr = 2;
        @(negedge clk);
        total++; if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0)
            begin bad++; $display("FAIL stall_release got v=%b busy=%b want 0 0", bus.rsp_valid_o, bus.busy_o); end
    endtask

    task automatic test_timeout();
        mute = 1'b1;
        push_op(1, 16'h4000);
        engine(1, 60, 1'b0);
        model_ptr = 2;
        mute = 1'b0;
        total++; if (timed_out || obs_id.size() != 1 || obs_id[0] !== 1 || obs_data[0] !== 16'h7FC0 || obs_err[0] !== 1'b1)
            begin bad++; $display("FAIL timeout_rsp got n=%0d want id=1 data=7fc0 err=1", obs_id.size()); end
        total++; if (rv_cyc.size() != 1 || acc_cyc.size() != 1 || rv_cyc[0] - acc_cyc[0] != TO + 2)
            begin bad++; $display("FAIL timeout_cycles got acc=%0d rv=%0d want diff=%0d", acc_cyc.size(), rv_cyc.size(), TO + 2); end
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", bus.err_o); end
        clear_bench();
        @(negedge clk);
        inj_cnt++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.err_o !== 1'b1) begin
                bad++;
                $display("FAIL late_pulse[%0d] got v=%b busy=%b err=%b want 0 0 1", c, bus.rsp_valid_o, bus.busy_o, bus.err_o);
            end
        end
        lat = 2;
        push_op(2, 16'h0000);
        build_expect();
        engine(1, 60, 1'b0);
        total++; if (timed_out || obs_id.size() != 1 || obs_id[0] !== exp_id[0] || obs_data[0] !== exp_data[0] || obs_err[0] !== 1'b0)
            begin bad++; $display("FAIL post_timeout_rsp got n=%0d want id=%0d data=%h err=0", obs_id.size(), exp_id[0], exp_data[0]); end
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.err_o); end
        clear_bench();
    endtask

    task automatic test_stray();
        do_reset();
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL stray_pre got=%b want=0", bus.err_o); end
        inj_cnt++;
        repeat (3) @(negedge clk);
        total++; if (bus.err_o !== 1'b1 || bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0)
            begin bad++; $display("FAIL stray_idle got err=%b v=%b busy=%b want 1 0 0", bus.err_o, bus.rsp_valid_o, bus.busy_o); end
    endtask

    task automatic test_random();
        int ic;
        do_reset();
        for (int round = 0; round < 4; round++) begin
            for (int r = 0; r < N; r++) begin
                int n;
                n = $urandom_range(0, 4);
                for (int j = 0; j < n; j++) push_op(r, 16'($urandom));
            end
            if (tail[round % N] == 0) push_op(round % N, 16'($urandom));
            build_expect();
            ic = issue_cnt;
            rand_lat = 1'b1;
            engine(exp_id.size(), 600, 1'b1);
            rand_lat = 1'b0;
            total++; if (timed_out || obs_id.size() != exp_id.size())
                begin bad++; $display("FAIL rand_count[%0d] got=%0d want=%0d", round, obs_id.size(), exp_id.size()); end
            total++; if (issue_cnt - ic != exp_id.size())
                begin bad++; $display("FAIL rand_issue[%0d] got=%0d want=%0d", round, issue_cnt - ic, exp_id.size()); end
            for (int k = 0; k < obs_id.size() && k < exp_id.size(); k++) begin
                total++;
                if (obs_id[k] !== exp_id[k] || obs_data[k] !== exp_data[k] || obs_err[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_rsp[%0d.%0d] got id=%0d data=%h err=%b want id=%0d data=%h err=0",
                             round, k, obs_id[k], obs_data[k], obs_err[k], exp_id[k], exp_data[k]);
                end
            end
            clear_bench();
        end
    endtask

    task automatic test_reset_midop();
        bit ok = 1'b0;
        lat = 1;
        push_op(2, 16'h4000);
        build_expect();
        engine(1, 50, 1'b0);
        total++; if (timed_out || obs_id.size() != 1 || obs_id[0] !== 2)
            begin bad++; $display("FAIL midop_setup got n=%0d want id=2", obs_id.size()); end
        clear_bench();
        mute = 1'b1;
        @(posedge clk); #1;
        bus.req_valid_i = 4'b1000;
        bus.req_data_i[63:48] = 16'h3F80;
        for (int c = 0; c < 20 && !ok; c++) begin @(negedge clk); ok = bus.req_ready_o[3]; end
        @(posedge clk); #1;
        bus.req_valid_i = '0;
        repeat (3) @(negedge clk);
        total++; if (!ok || bus.busy_o !== 1'b1) begin bad++; $display("FAIL midop_wait got grant=%b busy=%b want 1 1", ok, bus.busy_o); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (bus.busy_o !== 1'b0 || bus.flog_valid_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || bus.err_o !== 1'b0)
            begin bad++; $display("FAIL midop_async got busy=%b fv=%b rv=%b err=%b want 0", bus.busy_o, bus.flog_valid_o, bus.rsp_valid_o, bus.err_o); end
        total++; if ({bus.flog_sign_o, bus.flog_exp_o, bus.flog_fract_o} !== 16'h0 || bus.rsp_id_o !== '0)
            begin bad++; $display("FAIL midop_async_data got op=%h id=%0d want 0", {bus.flog_sign_o, bus.flog_exp_o, bus.flog_fract_o}, bus.rsp_id_o); end
        @(negedge clk);
        rst = 1'b1;
        mute = 1'b0;
        model_ptr = 0;
        clear_bench();
        push_op(1, 16'h7F80);
        push_op(3, 16'hBF80);
        build_expect();
        engine(2, 80, 1'b0);
        total++; if (timed_out || obs_id.size() != 2 || grant_log[0] !== 1)
            begin bad++; $display("FAIL midop_ptr got n=%0d want first grant=1", obs_id.size()); end
        for (int k = 0; k < obs_id.size() && k < exp_id.size(); k++) begin
            total++;
            if (obs_id[k] !== exp_id[k] || obs_data[k] !== exp_data[k] || obs_err[k] !== 1'b0) begin
                bad++;
                $display("FAIL midop_rsp[%0d] got id=%0d data=%h want id=%0d data=%h", k, obs_id[k], obs_data[k], exp_id[k], exp_data[k]);
            end
        end
        clear_bench();
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.rsp_ready_i = 1'b0;
        clear_bench();
        test_reset();
        test_single();
        test_req2_pair();
        test_all_four();
        test_stall();
        test_timeout();
        test_stray();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=still running want=finished");
        $fatal(1);
    end
endmodule
